// File: rtl/hall_sensor_decoder.sv
// Hall sensor front end: synchronise, glitch-filter, sequence-check, direction, period and stall.
// Defining HALL_POS_CNT_EN adds the pos_clr input and the signed pos output.
module hall_sensor_decoder #(
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned PER_W       = 20,
    parameter int unsigned STALL_CYC   = 1000000
`ifdef HALL_POS_CNT_EN
    , parameter int unsigned POS_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       hall_in,
    input  logic             fault_clr,
`ifdef HALL_POS_CNT_EN
    input  logic             pos_clr,
`endif
    output logic [2:0]       h_out,
    output logic             dir,
    output logic             hall_valid,
    output logic             fault,
    output logic             edge_stb,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             stall
`ifdef HALL_POS_CNT_EN
    , output logic signed [POS_W-1:0] pos
`endif
);

    localparam int unsigned CNT_W = 8;

    logic [2:0]       s1, s2, cand, acc;
    logic [CNT_W-1:0] filt_cnt, stable_n;
    logic [PER_W-1:0] per_cnt;
    logic             first_code, armed;
    logic             accept, illegal, fwd, rev, resync, valid_edge, fault_evt;
    logic [2:0]       new_idx, cur_idx, step;
    logic [3:0]       diff;

    // Position of a code in the forward ring; 7 marks 000/111.
    function automatic logic [2:0] idx_of(input logic [2:0] code);
        case (code)
            3'b001:  idx_of = 3'd0;
            3'b011:  idx_of = 3'd1;
            3'b010:  idx_of = 3'd2;
            3'b110:  idx_of = 3'd3;
            3'b100:  idx_of = 3'd4;
            3'b101:  idx_of = 3'd5;
            default: idx_of = 3'd7;
        endcase
    endfunction

    always_comb begin
        stable_n = CNT_W'(1);
        if (s2 == cand)
            stable_n = (filt_cnt == '1) ? filt_cnt : filt_cnt + CNT_W'(1);
        accept     = (s2 != acc) && (stable_n >= CNT_W'(FILT_CYCLES));
        new_idx    = idx_of(s2);
        cur_idx    = idx_of(h_out);
        illegal    = (new_idx == 3'd7);
        // Ring distance from the current code to the candidate, 0..5.
        diff       = 4'(new_idx) + 4'd6 - 4'(cur_idx);
        step       = (diff >= 4'd6) ? 3'(diff - 4'd6) : 3'(diff);
        fwd        = accept && !illegal && !first_code && (step == 3'd1);
        rev        = accept && !illegal && !first_code && (step == 3'd5);
        resync     = accept && !illegal && !first_code && (step inside {3'd2, 3'd3, 3'd4});
        valid_edge = fwd || rev;
        fault_evt  = accept && (illegal || resync);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s2         <= '0;
            cand       <= '0;
            acc        <= '0;
            filt_cnt   <= '0;
            per_cnt    <= '0;
            first_code <= 1'b1;
            armed      <= 1'b0;
            h_out      <= '0;
            dir        <= 1'b0;
            hall_valid <= 1'b0;
            fault      <= 1'b0;
            edge_stb   <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
            stall      <= 1'b0;
        end else begin
            s1       <= hall_in;
            s2       <= s1;
            cand     <= s2;
            filt_cnt <= stable_n;
            if (accept)
                acc <= s2;

            if (accept && !illegal && first_code) begin
                h_out      <= s2;
                hall_valid <= 1'b1;
                first_code <= 1'b0;
            end
            if (valid_edge || resync)
                h_out <= s2;
            if (fwd)
                dir <= 1'b1;
            if (rev)
                dir <= 1'b0;
            edge_stb <= valid_edge;

            // A new fault event takes priority over a coincident clear.
            fault <= fault_evt || (fault && !fault_clr);

            if (valid_edge) begin
                per_cnt    <= '0;
                period     <= (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);
                period_vld <= armed;
                armed      <= 1'b1;
                stall      <= 1'b0;
            end else if (resync) begin
                per_cnt    <= '0;
                period_vld <= 1'b0;
                armed      <= 1'b0;
            end else begin
                if (per_cnt != '1)
                    per_cnt <= per_cnt + PER_W'(1);
                if (per_cnt == PER_W'(STALL_CYC - 1)) begin
                    stall      <= 1'b1;
                    period_vld <= 1'b0;
                    period     <= '1;
                    armed      <= 1'b0;
                end
            end
        end
    end

`ifdef HALL_POS_CNT_EN
    // Signed electrical position; a clear masks any coincident edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pos <= '0;
        else if (pos_clr)
            pos <= '0;
        else if (fwd)
            pos <= pos + POS_W'(1);
        else if (rev)
            pos <= pos - POS_W'(1);
    end
`endif

endmodule

// File: tb/tb_hall_sensor_decoder.sv
// Bench for hall_sensor_decoder: directed scenarios plus random hall traffic against a reference model.
module tb_hall_sensor_decoder;

    localparam int unsigned FILT  = 4;
    localparam int unsigned PER_W = 20;
    localparam int unsigned STALL = 500;
    localparam int unsigned POS_W = 16;
    localparam logic [PER_W-1:0] ONES = '1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       hall_in = 3'b000;
    logic             fault_clr = 1'b0;
    logic [2:0]       h_out;
    logic             dir, hall_valid, fault, edge_stb, period_vld, stall;
    logic [PER_W-1:0] period;
`ifdef HALL_POS_CNT_EN
    logic                    pos_clr = 1'b0;
    logic signed [POS_W-1:0] pos;
`endif

    int errors = 0;
    int checks = 0;
    int stb_cnt = 0;

    always #5 clk = ~clk;

    hall_sensor_decoder #(
        .FILT_CYCLES(FILT),
        .PER_W      (PER_W),
        .STALL_CYC  (STALL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hall_in   (hall_in),
        .fault_clr (fault_clr),
`ifdef HALL_POS_CNT_EN
        .pos_clr   (pos_clr),
`endif
        .h_out     (h_out),
        .dir       (dir),
        .hall_valid(hall_valid),
        .fault     (fault),
        .edge_stb  (edge_stb),
        .period    (period),
        .period_vld(period_vld),
        .stall     (stall)
`ifdef HALL_POS_CNT_EN
        , .pos     (pos)
`endif
    );

    function automatic logic [2:0] seq_code(input int i);
        logic [2:0] ring [6];
        ring = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
        return ring[((i % 6) + 6) % 6];
    endfunction

    function automatic int seq_pos(input logic [2:0] c);
        for (int i = 0; i < 6; i++)
            if (seq_code(i) == c) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample history, timestamps and ring arithmetic.
    logic [2:0]       m_h, m_acc;
    logic             m_dir, m_valid, m_fault, m_stb, m_pvld, m_stall, m_first;
    logic [PER_W-1:0] m_period;
    longint           m_n, m_t0;
    int               m_edges, m_pos;
    logic [2:0]       pipe [$];
    logic [2:0]       win [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h = 3'b000; m_acc = 3'b000; m_dir = 0; m_valid = 0; m_fault = 0; m_stb = 0;
            m_pvld = 0; m_stall = 0; m_first = 1; m_period = '0;
            m_n = 0; m_t0 = 0; m_edges = 0; m_pos = 0;
            pipe = '{3'b000, 3'b000};
            win = {};
        end else begin
            logic [2:0] v;
            bit         take, fevt, vedge, rsync;
            int         pn, d;
            longint     el;
            m_n++;
            v = pipe.pop_front();
            pipe.push_back(hall_in);
            win.push_back(v);
            if (win.size() > FILT) void'(win.pop_front());
            take = (win.size() == FILT) && (v != m_acc);
            foreach (win[i]) if (win[i] != v) take = 0;
            m_stb = 0; fevt = 0; vedge = 0; rsync = 0; d = 0;
            if (take) begin
                m_acc = v;
                pn = seq_pos(v);
                if (pn < 0) fevt = 1;
                else if (m_first) begin
                    m_h = v; m_valid = 1; m_first = 0;
                end else begin
                    d = (pn - seq_pos(m_h) + 6) % 6;
                    if (d == 1 || d == 5) begin
                        vedge = 1; m_stb = 1; m_dir = (d == 1); m_h = v;
                    end else if (d != 0) begin
                        rsync = 1; fevt = 1; m_h = v;
                    end
                end
            end
            el = m_n - m_t0;
            if (vedge) begin
                m_period = (el >= longint'(ONES)) ? ONES : PER_W'(el);
                m_edges++;
                m_pvld = (m_edges >= 2);
                m_stall = 0;
                m_t0 = m_n;
            end else if (rsync) begin
                m_t0 = m_n; m_edges = 0; m_pvld = 0;
            end else if (el == longint'(STALL)) begin
                m_stall = 1; m_pvld = 0; m_period = ONES; m_edges = 0;
            end
            if (fevt) m_fault = 1;
            else if (fault_clr) m_fault = 0;
`ifdef HALL_POS_CNT_EN
            if (pos_clr) m_pos = 0;
            else if (vedge) m_pos = m_pos + ((d == 1) ? 1 : -1);
`endif
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("h_out",      32'(h_out),      32'(m_h));
        chk("dir",        32'(dir),        32'(m_dir));
        chk("hall_valid", 32'(hall_valid), 32'(m_valid));
        chk("fault",      32'(fault),      32'(m_fault));
        chk("edge_stb",   32'(edge_stb),   32'(m_stb));
        chk("period",     32'(period),     32'(m_period));
        chk("period_vld", 32'(period_vld), 32'(m_pvld));
        chk("stall",      32'(stall),      32'(m_stall));
`ifdef HALL_POS_CNT_EN
        chk("pos", 32'($unsigned(pos)), 32'($unsigned(POS_W'(m_pos))));
`endif
        if (edge_stb === 1'b1) stb_cnt++;
    end

    task automatic hold(input logic [2:0] c, input int n);
        hall_in = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fault_clr();
        fault_clr = 1'b1;
        @(posedge clk);
        #1 fault_clr = 1'b0;
    endtask

    task automatic pulse_pos_clr();
`ifdef HALL_POS_CNT_EN
        pos_clr = 1'b1;
        @(posedge clk);
        #1 pos_clr = 1'b0;
`else
        @(posedge clk);
        #1;
`endif
    endtask

    initial begin
        int         e0, r, p, dur;
        logic [2:0] drv, back;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_h_out", 32'(h_out), 32'd0);
        chk("rst_valid", 32'(hall_valid), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // Forward steps every 100 clocks.
        e0 = stb_cnt;
        hold(3'b001, 100);
        chk("first_h_out", 32'(h_out), 32'd1);
        chk("first_valid", 32'(hall_valid), 32'd1);
        chk("first_no_stb", 32'(stb_cnt - e0), 32'd0);
        hold(3'b011, 100);
        chk("edge1_pvld", 32'(period_vld), 32'd0);
        hold(3'b010, 100);
        hold(3'b110, 100);
        chk("fwd_stb", 32'(stb_cnt - e0), 32'd3);
        chk("fwd_dir", 32'(dir), 32'd1);
        chk("fwd_period", 32'(period), 32'd100);
        chk("fwd_pvld", 32'(period_vld), 32'd1);

        // Reverse steps.
        pulse_pos_clr();
        e0 = stb_cnt;
        hold(3'b010, 100);
        hold(3'b011, 100);
        hold(3'b001, 100);
        chk("rev_stb", 32'(stb_cnt - e0), 32'd3);
        chk("rev_dir", 32'(dir), 32'd0);
        chk("rev_period", 32'(period), 32'd100);
`ifdef HALL_POS_CNT_EN
        chk("rev_pos", 32'($unsigned(pos)), 32'h0000_FFFD);
`endif

        // Glitch one clock shorter than the filter.
        e0 = stb_cnt;
        hold(3'b011, FILT - 1);
        hold(3'b001, 50);
        chk("glitch_h_out", 32'(h_out), 32'd1);
        chk("glitch_stb", 32'(stb_cnt - e0), 32'd0);

        // Illegal code, then clear.
        hold(3'b111, 20);
        chk("ill_fault", 32'(fault), 32'd1);
        chk("ill_h_out", 32'(h_out), 32'd1);
        hold(3'b001, 20);
        pulse_fault_clr();
        chk("clr_fault", 32'(fault), 32'd0);

        // Out-of-sequence jump.
        e0 = stb_cnt;
        hold(3'b110, 50);
        chk("jump_fault", 32'(fault), 32'd1);
        chk("jump_h_out", 32'(h_out), 32'd6);
        chk("jump_pvld", 32'(period_vld), 32'd0);
        chk("jump_stb", 32'(stb_cnt - e0), 32'd0);
        pulse_fault_clr();

        // Stall and recovery.
        hold(3'b110, STALL + 10);
        chk("stall_set", 32'(stall), 32'd1);
        chk("stall_period", 32'(period), 32'(ONES));
        chk("stall_pvld", 32'(period_vld), 32'd0);
        e0 = stb_cnt;
        hold(3'b100, 20);
        chk("unstall", 32'(stall), 32'd0);
        chk("unstall_pvld", 32'(period_vld), 32'd0);
        chk("unstall_stb", 32'(stb_cnt - e0), 32'd1);

        // Random traffic.
        drv = 3'b100;
        for (int s = 0; s < 400; s++) begin
            r = int'($urandom_range(0, 99));
            p = seq_pos(drv);
            if (p < 0) p = 0;
            if (r < 60) begin
                drv = seq_code(p + (($urandom_range(0, 1) == 1) ? 1 : -1));
                hold(drv, int'($urandom_range(5, 150)));
            end else if (r < 70) begin
                back = drv;
                hold(3'($urandom_range(0, 7)), int'($urandom_range(1, FILT - 1)));
                hold(back, int'($urandom_range(5, 40)));
            end else if (r < 78) begin
                drv = 3'($urandom_range(0, 7));
                hold(drv, int'($urandom_range(1, 8)));
            end else if (r < 84) begin
                drv = seq_code(int'($urandom_range(0, 5)));
                hold(drv, int'($urandom_range(5, 60)));
            end else if (r < 88) begin
                hold(drv, int'(STALL) + int'($urandom_range(0, 50)));
            end else if (r < 94) begin
                pulse_fault_clr();
            end else if (r < 97) begin
                pulse_pos_clr();
            end else begin
                #2 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #3 rst_n = 1'b1;
            end
        end
        hold(drv, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
